// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared op codes, state encodings and byte-mask constants for the load/store controller
package lsu_ctrl_pkg;
    localparam int ALU_OP_W = 8;
    localparam int MEM_ADDR_W = 32;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LB  = 8'he0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LH  = 8'he1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LW  = 8'he3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LBU = 8'he4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LHU = 8'he5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SB  = 8'he8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SH  = 8'he9;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SW  = 8'heb;
    localparam logic [31:0] ZERO_WORD = 32'h0;
    localparam logic [3:0] LSU_MASK_NONE = 4'b0000;
    localparam logic [3:0] LSU_MASK_B    = 4'b0001;
    localparam logic [3:0] LSU_MASK_H    = 4'b0011;
    localparam logic [3:0] LSU_MASK_W    = 4'b1111;
    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;
    function automatic logic op_is_load(input logic [ALU_OP_W-1:0] op);
        return op == ALU_OP_LB || op == ALU_OP_LH || op == ALU_OP_LW || op == ALU_OP_LBU || op == ALU_OP_LHU;
    endfunction
    function automatic logic op_is_store(input logic [ALU_OP_W-1:0] op);
        return op == ALU_OP_SB || op == ALU_OP_SH || op == ALU_OP_SW;
    endfunction
endpackage

// File: rtl/lsu_ctrl_store_align.sv
// lsu_store_align: op + byte offset + store data -> byte mask, lane-shifted data, misalign flag (flag only with LSU_MISALIGN_TRAP_EN)
module lsu_store_align
    import lsu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [1:0]          off,
    input  logic [DATA_W-1:0]   wdata,
    output logic [3:0]          mask,
    output logic [DATA_W-1:0]   wdata_sh,
    output logic                is_mem,
    output logic                is_store
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                misalign
`endif
);
    assign is_store = op_is_store(op);
    assign is_mem   = is_store || op_is_load(op);
    // lane bits shifted past byte 3 fall off the 4-bit mask
    assign mask = op == ALU_OP_SB ? LSU_MASK_B << off :
                  op == ALU_OP_SH ? LSU_MASK_H << off :
                  op == ALU_OP_SW ? LSU_MASK_W : LSU_MASK_NONE;
    assign wdata_sh = is_store ? wdata << {off, 3'b000} : '0;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((op == ALU_OP_LH || op == ALU_OP_LHU || op == ALU_OP_SH) && off[0]) ||
                      ((op == ALU_OP_LW || op == ALU_OP_SW) && off != 2'b00);
`endif
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store sequencer; optional misalign trap via LSU_MISALIGN_TRAP_EN
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ALU_OP_W-1:0]   alu_op_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [3:0]            mem_wmask_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_W-1:0]     rmem_data_o,
    output logic [MEM_ADDR_W-1:0] read_offset_o,
    output logic [ALU_OP_W-1:0]   alu_op_o
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_o
`endif
);
    lsu_state_e state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [3:0] mask_q, mask;
    logic [DATA_W-1:0] wdata_sh;
    logic [ALU_OP_W-1:0] op_q;
    logic we_q, is_mem, is_store, trap;
    logic accept;

    lsu_store_align #(.DATA_W(DATA_W)) u_align (
        .op       (alu_op_i),
        .off      (addr_i[1:0]),
        .wdata    (wdata_i),
        .mask     (mask),
        .wdata_sh (wdata_sh),
        .is_mem   (is_mem),
        .is_store (is_store)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign (trap)
`endif
    );

`ifndef LSU_MISALIGN_TRAP_EN
    assign trap = 1'b0;
`endif

    assign accept        = state == LSU_IDLE && req_valid_i;
    assign req_ready_o   = state == LSU_IDLE;
    assign mem_valid_o   = state == LSU_REQ;
    assign resp_valid_o  = state == LSU_RESP;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata_o   = wdata_q;
    assign mem_wmask_o   = mask_q;
    assign rmem_data_o   = rdata_q;
    assign read_offset_o = {30'b0, addr_q[1:0]};
    assign alu_op_o      = op_q;

    // request capture and IDLE/REQ/WAIT/RESP sequencing; request fields only change on accept so they stay stable in REQ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LSU_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mask_q  <= '0;
            op_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: if (req_valid_i) begin
                    op_q    <= alu_op_i;
                    addr_q  <= addr_i;
                    wdata_q <= wdata_sh;
                    mask_q  <= mask;
                    we_q    <= is_store;
                    rdata_q <= ZERO_WORD;
                    state   <= (!is_mem || trap) ? LSU_RESP : LSU_REQ;
                end
                LSU_REQ: if (mem_ready_i) begin
                    if (mem_rvalid_i)
                        rdata_q <= we_q ? ZERO_WORD : mem_rdata_i;
                    state <= mem_rvalid_i ? LSU_RESP : LSU_WAIT;
                end
                LSU_WAIT: if (mem_rvalid_i) begin
                    rdata_q <= we_q ? ZERO_WORD : mem_rdata_i;
                    state   <= LSU_RESP;
                end
                LSU_RESP: if (resp_ready_i)
                    state <= LSU_IDLE;
                default: state <= LSU_IDLE;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign misalign_o = misalign_q;
    // misalign flag latched with the request and held through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (accept)
            misalign_q <= trap;
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl (also covers LSU_MISALIGN_TRAP_EN builds)
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic clk = 1'b0, rst = 1'b1;
    logic req_valid_i = 0, req_ready_o;
    logic [7:0] alu_op_i = '0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic mem_valid_o, mem_ready_i = 0, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0] mem_wmask_o;
    logic mem_rvalid_i = 0;
    logic [31:0] mem_rdata_i = '0;
    logic resp_valid_o, resp_ready_i = 0;
    logic [31:0] rmem_data_o, read_offset_o;
    logic [7:0] alu_op_o;
`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_o;
`endif

    lsu_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .alu_op_i(alu_op_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .rmem_data_o(rmem_data_o), .read_offset_o(read_offset_o), .alu_op_o(alu_op_o)
`ifdef LSU_MISALIGN_TRAP_EN
        , .misalign_o(misalign_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] off;
        logic [7:0]  op;
        logic        mis;
    } resp_t;
    resp_t sb[$];
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_resp(input string t, input resp_t e);
        check({t, " rmem_data"}, rmem_data_o, e.rdata);
        check({t, " offset"}, read_offset_o, e.off);
        check({t, " alu_op"}, {24'b0, alu_op_o}, {24'b0, e.op});
`ifdef LSU_MISALIGN_TRAP_EN
        check({t, " misalign"}, {31'b0, misalign_o}, {31'b0, e.mis});
`endif
    endtask

    // mem: op reaches memory; ld: load; mis: trap expected (only meaningful with the trap build)
    task automatic run_op(input string t, input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit mem, input bit ld, input bit mis, input int rdy_dly, input int rv_dly,
                          input int resp_dly, input logic [31:0] rdata, input logic [3:0] emask,
                          input logic [31:0] ewdata, input bit ewe);
        resp_t e;
        int acc, n, lat;
        check({t, " req_ready idle"}, {31'b0, req_ready_o}, 32'd1);
        e.rdata = (mem && ld && !mis) ? rdata : 32'h0;
        e.off   = {30'b0, addr[1:0]};
        e.op    = op;
        e.mis   = mis;
        sb.push_back(e);
        req_valid_i = 1; alu_op_i = op; addr_i = addr; wdata_i = wdata;
        acc = cyc;
        step;
        req_valid_i = 0; alu_op_i = '0; addr_i = '0; wdata_i = '0;
        if (mem && !mis) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                check({t, " mem_valid"}, {31'b0, mem_valid_o}, 32'd1);
                check({t, " mem_addr"}, mem_addr_o, {addr[31:2], 2'b00});
                check({t, " mem_wmask"}, {28'b0, mem_wmask_o}, {28'b0, emask});
                check({t, " mem_wdata"}, mem_wdata_o, ewdata);
                check({t, " mem_we"}, {31'b0, mem_we_o}, {31'b0, ewe});
                mem_ready_i  = (i == rdy_dly);
                mem_rvalid_i = (i == rdy_dly) && (rv_dly == 0);
                mem_rdata_i  = rdata;
                step;
            end
            mem_ready_i = 0; mem_rvalid_i = 0;
            if (rv_dly > 0) begin
                check({t, " mem_valid wait"}, {31'b0, mem_valid_o}, 32'd0);
                repeat (rv_dly - 1) step;
                mem_rvalid_i = 1;
                step;
                mem_rvalid_i = 0;
            end
        end else begin
            check({t, " no mem_valid"}, {31'b0, mem_valid_o}, 32'd0);
        end
        n = 0;
        while (!resp_valid_o && n < 10) begin
            step;
            n++;
        end
        check({t, " resp_valid"}, {31'b0, resp_valid_o}, 32'd1);
        if (!resp_valid_o) begin
            void'(sb.pop_front());
            return;
        end
        lat = (!mem || mis) ? 1 : 2 + rdy_dly + rv_dly;
        check({t, " latency"}, cyc - acc, lat);
        for (int i = 0; i < resp_dly; i++) begin
            check({t, " req_ready hold"}, {31'b0, req_ready_o}, 32'd0);
            check({t, " resp_valid hold"}, {31'b0, resp_valid_o}, 32'd1);
            check_resp({t, " hold"}, sb[0]);
            step;
        end
        resp_ready_i = 1;
        check_resp(t, sb.pop_front());
        step;
        resp_ready_i = 0;
        check({t, " resp drop"}, {31'b0, resp_valid_o}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        step;
        check("rst req_ready", {31'b0, req_ready_o}, 32'd1);
        check("rst mem_valid", {31'b0, mem_valid_o}, 32'd0);
        check("rst mem_we", {31'b0, mem_we_o}, 32'd0);
        check("rst mem_addr", mem_addr_o, 32'd0);
        check("rst mem_wmask", {28'b0, mem_wmask_o}, 32'd0);
        check("rst mem_wdata", mem_wdata_o, 32'd0);
        check("rst resp_valid", {31'b0, resp_valid_o}, 32'd0);
        check("rst rmem", rmem_data_o, 32'd0);
        check("rst offset", read_offset_o, 32'd0);
        check("rst alu_op", {24'b0, alu_op_o}, 32'd0);
        rst = 0;
        step;
        mem_rvalid_i = 1; mem_rdata_i = 32'h55555555;
        step;
        mem_rvalid_i = 0;
        check("idle rvalid ignored", {31'b0, resp_valid_o}, 32'd0);

        run_op("lw",   ALU_OP_LW,  32'h1000, 32'h0,        1, 1, 0, 0, 1, 0, 32'hDEADBEEF, 4'b0000, 32'h0,        0);
        run_op("sb",   ALU_OP_SB,  32'h2003, 32'h000000A5, 1, 0, 0, 0, 1, 0, 32'h12345678, 4'b1000, 32'hA5000000, 1);
        run_op("lhu",  ALU_OP_LHU, 32'h3002, 32'h0,        1, 1, 0, 4, 1, 0, 32'hCAFE0000, 4'b0000, 32'h0,        0);
        run_op("sh",   ALU_OP_SH,  32'h1006, 32'h00001234, 1, 0, 0, 0, 0, 0, 32'h9999AAAA, 4'b1100, 32'h12340000, 1);
        run_op("lb",   ALU_OP_LB,  32'h4001, 32'h0,        1, 1, 0, 1, 0, 3, 32'h00007700, 4'b0000, 32'h0,        0);
        run_op("sw",   ALU_OP_SW,  32'h5000, 32'h11223344, 1, 0, 0, 0, 2, 0, 32'hFFFFFFFF, 4'b1111, 32'h11223344, 1);
        run_op("sb1",  ALU_OP_SB,  32'h5001, 32'hFFFFFF3C, 1, 0, 0, 0, 1, 0, 32'h0,        4'b0010, 32'hFFFF3C00, 1);
        run_op("nop",  8'h21,      32'h7002, 32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        0);
`ifdef LSU_MISALIGN_TRAP_EN
        run_op("lw mis", ALU_OP_LW, 32'h1001, 32'h0,        1, 1, 1, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 0);
        run_op("sh mis", ALU_OP_SH, 32'h2003, 32'h0000ABCD, 1, 0, 1, 0, 0, 0, 32'h0, 4'b1000, 32'h0, 0);
`else
        run_op("lw mis", ALU_OP_LW, 32'h1001, 32'h0,        1, 1, 0, 0, 1, 0, 32'h87654321, 4'b0000, 32'h0,        0);
        run_op("sh mis", ALU_OP_SH, 32'h2003, 32'h0000ABCD, 1, 0, 0, 0, 1, 0, 32'h0,        4'b1000, 32'hCD000000, 1);
`endif

        alu_op_i = ALU_OP_LW; addr_i = 32'h6000; req_valid_i = 1;
        step;
        req_valid_i = 0;
        mem_ready_i = 1;
        step;
        mem_ready_i = 0;
        check("rst-wait in wait", {31'b0, mem_valid_o | resp_valid_o}, 32'd0);
        rst = 1;
        #1;
        check("rst-wait async ready", {31'b0, req_ready_o}, 32'd1);
        step;
        rst = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0BAD0;
        step;
        mem_rvalid_i = 0;
        for (int i = 0; i < 3; i++) begin
            check("rst-wait no resp", {31'b0, resp_valid_o}, 32'd0);
            check("rst-wait idle", {31'b0, req_ready_o}, 32'd1);
            step;
        end
        check("rst-wait rmem", rmem_data_o, 32'd0);
        check("scoreboard empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got %0d expected done", cyc);
        $fatal(1);
    end
endmodule
